// File: rtl/gimli_stream_out_arbiter.sv
// Two-source packet arbiter feeding a single-entry output register; a source keeps the
// grant until its last beat. Define GIMLI_OUT_ARB_FIXED_PRIORITY_EN for fixed priority (source 0 first).
module gimli_stream_out_arbiter #(
  parameter int unsigned DIN_WIDTH      = 128,
  parameter int unsigned DIN_SIZE_WIDTH = 4,
  localparam int unsigned SIZE_W        = DIN_SIZE_WIDTH + 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [DIN_WIDTH-1:0] s0_din,
  input  logic [SIZE_W-1:0]    s0_din_size,
  input  logic                 s0_din_last,
  input  logic                 s0_din_valid,
  output logic                 s0_din_ready,
  input  logic [DIN_WIDTH-1:0] s1_din,
  input  logic [SIZE_W-1:0]    s1_din_size,
  input  logic                 s1_din_last,
  input  logic                 s1_din_valid,
  output logic                 s1_din_ready,
  output logic [DIN_WIDTH-1:0] m_dout,
  output logic [SIZE_W-1:0]    m_dout_size,
  output logic                 m_dout_last,
  output logic                 m_dout_valid,
  input  logic                 m_dout_ready,
  output logic                 m_dout_src,
  output logic [1:0]           owner,
  output logic [7:0]           pkt_cnt0,
  output logic [7:0]           pkt_cnt1
);

  // Encoding doubles as the one-hot owner value.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    LOCK0 = 2'b01,
    LOCK1 = 2'b10
  } state_t;

  state_t state, state_nxt;
  logic   accept_ok;
  logic   sel;
  logic   take;
  logic   sel_last;

`ifndef GIMLI_OUT_ARB_FIXED_PRIORITY_EN
  logic   ptr;
`endif

  // Grant, readies and next state; readies are forced low while reset is held.
  always_comb begin
    state_nxt    = state;
    sel          = 1'b0;
    s0_din_ready = 1'b0;
    s1_din_ready = 1'b0;
    accept_ok    = rstn & (~m_dout_valid | m_dout_ready);
    case (state)
      IDLE: begin
`ifdef GIMLI_OUT_ARB_FIXED_PRIORITY_EN
        sel = ~s0_din_valid;
`else
        sel = (s0_din_valid & s1_din_valid) ? ~ptr : ~s0_din_valid;
`endif
        s0_din_ready = accept_ok & ~sel & s0_din_valid;
        s1_din_ready = accept_ok &  sel & s1_din_valid;
      end
      LOCK0: begin
        sel          = 1'b0;
        s0_din_ready = accept_ok;
      end
      LOCK1: begin
        sel          = 1'b1;
        s1_din_ready = accept_ok;
      end
      default: state_nxt = IDLE;
    endcase
    take     = sel ? (s1_din_valid & s1_din_ready) : (s0_din_valid & s0_din_ready);
    sel_last = sel ? s1_din_last : s0_din_last;
    if (take) begin
      if (state == IDLE && !sel_last) begin
        state_nxt = sel ? LOCK1 : LOCK0;
      end else if (state != IDLE && sel_last) begin
        state_nxt = IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  assign owner = 2'(state);

  // Output register: a drain and a fresh load in the same cycle keep it full.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_dout_valid <= 1'b0;
      m_dout       <= '0;
      m_dout_size  <= '0;
      m_dout_last  <= 1'b0;
      m_dout_src   <= 1'b0;
    end else if (take) begin
      m_dout_valid <= 1'b1;
      m_dout       <= sel ? s1_din      : s0_din;
      m_dout_size  <= sel ? s1_din_size : s0_din_size;
      m_dout_last  <= sel_last;
      m_dout_src   <= sel;
    end else if (m_dout_ready) begin
      m_dout_valid <= 1'b0;
    end
  end

  // Packet counters and round-robin pointer advance on each accepted last beat.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pkt_cnt0 <= 8'd0;
      pkt_cnt1 <= 8'd0;
    end else if (take && sel_last) begin
      if (sel) begin
        pkt_cnt1 <= pkt_cnt1 + 8'd1;
      end else begin
        pkt_cnt0 <= pkt_cnt0 + 8'd1;
      end
    end
  end

`ifndef GIMLI_OUT_ARB_FIXED_PRIORITY_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr <= 1'b1;
    end else if (take && sel_last) begin
      ptr <= sel;
    end
  end
`endif

endmodule

// File: tb/tb_gimli_stream_out_arbiter.sv
// Directed bench for gimli_stream_out_arbiter: grant order, locking, backpressure, reset, counter wrap.
module tb_gimli_stream_out_arbiter;
  localparam int unsigned DW = 128;
  localparam int unsigned SW = 5;

  logic          clk  = 1'b0;
  logic          rstn = 1'b1;
  logic [DW-1:0] s0_din, s1_din, m_dout;
  logic [SW-1:0] s0_din_size, s1_din_size, m_dout_size;
  logic          s0_din_last, s0_din_valid, s0_din_ready;
  logic          s1_din_last, s1_din_valid, s1_din_ready;
  logic          m_dout_last, m_dout_valid, m_dout_ready, m_dout_src;
  logic [1:0]    owner;
  logic [7:0]    pkt_cnt0, pkt_cnt1;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_cnt0 = 8'd0;
  logic [7:0] exp_cnt1 = 8'd0;

  gimli_stream_out_arbiter #(.DIN_WIDTH(DW), .DIN_SIZE_WIDTH(SW - 1)) dut (
    .clk(clk), .rstn(rstn),
    .s0_din(s0_din), .s0_din_size(s0_din_size), .s0_din_last(s0_din_last),
    .s0_din_valid(s0_din_valid), .s0_din_ready(s0_din_ready),
    .s1_din(s1_din), .s1_din_size(s1_din_size), .s1_din_last(s1_din_last),
    .s1_din_valid(s1_din_valid), .s1_din_ready(s1_din_ready),
    .m_dout(m_dout), .m_dout_size(m_dout_size), .m_dout_last(m_dout_last),
    .m_dout_valid(m_dout_valid), .m_dout_ready(m_dout_ready), .m_dout_src(m_dout_src),
    .owner(owner), .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic set_s0(input logic [DW-1:0] d, input logic [SW-1:0] sz, input logic last, input logic vld);
    s0_din = d; s0_din_size = sz; s0_din_last = last; s0_din_valid = vld;
  endtask

  task automatic set_s1(input logic [DW-1:0] d, input logic [SW-1:0] sz, input logic last, input logic vld);
    s1_din = d; s1_din_size = sz; s1_din_last = last; s1_din_valid = vld;
  endtask

  task automatic test_reset();
    m_dout_ready = 1'b1;
    set_s0(128'h11, 5'd16, 1'b1, 1'b1);
    set_s1(128'h22, 5'd16, 1'b1, 1'b1);
    #1 rstn = 1'b0;
    @(negedge clk);
    checks++; if ({s0_din_ready, s1_din_ready} !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b expected 00", {s0_din_ready, s1_din_ready}); end
    checks++; if (m_dout_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", m_dout_valid); end
    checks++; if (owner !== 2'b00) begin errors++; $display("FAIL reset_owner: got %b expected 00", owner); end
    checks++; if (pkt_cnt0 !== 8'd0 || pkt_cnt1 !== 8'd0) begin errors++; $display("FAIL reset_cnt: got %0d/%0d expected 0/0", pkt_cnt0, pkt_cnt1); end
    checks++; if (m_dout !== '0 || m_dout_size !== '0 || m_dout_src !== 1'b0 || m_dout_last !== 1'b0) begin errors++; $display("FAIL reset_outreg: got %0h/%0d/%b/%b expected 0", m_dout, m_dout_size, m_dout_src, m_dout_last); end
    set_s0('0, '0, 1'b0, 1'b0);
    set_s1('0, '0, 1'b0, 1'b0);
    exp_cnt0 = 8'd0; exp_cnt1 = 8'd0;
    @(negedge clk) rstn = 1'b1;
    @(posedge clk); #1;
  endtask

`ifndef GIMLI_OUT_ARB_FIXED_PRIORITY_EN
  task automatic test_round_robin();
    logic e;
    set_s0(128'hA0, 5'd16, 1'b1, 1'b1);
    set_s1(128'hB1, 5'd0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      e = (i % 2 == 1);
      @(negedge clk);
      checks++; if ({s0_din_ready, s1_din_ready} !== {~e, e}) begin errors++; $display("FAIL rr_ready[%0d]: got %b expected %b", i, {s0_din_ready, s1_din_ready}, {~e, e}); end
      @(posedge clk); #1;
      checks++; if (m_dout_src !== e || m_dout_valid !== 1'b1) begin errors++; $display("FAIL rr_src[%0d]: got src %b valid %b expected src %b valid 1", i, m_dout_src, m_dout_valid, e); end
      checks++; if (m_dout !== (e ? 128'hB1 : 128'hA0) || m_dout_size !== (e ? 5'd0 : 5'd16)) begin errors++; $display("FAIL rr_data[%0d]: got %0h size %0d", i, m_dout, m_dout_size); end
      if (e) exp_cnt1++; else exp_cnt0++;
    end
    s0_din_valid = 1'b0; s1_din_valid = 1'b0;
    checks++; if (pkt_cnt0 !== 8'd2 || pkt_cnt1 !== 8'd2) begin errors++; $display("FAIL rr_cnt: got %0d/%0d expected 2/2", pkt_cnt0, pkt_cnt1); end
    @(posedge clk); #1;
    checks++; if (m_dout_valid !== 1'b0) begin errors++; $display("FAIL rr_drain: got valid %b expected 0", m_dout_valid); end
  endtask
`else
  task automatic test_fixed_priority();
    set_s0(128'hA0, 5'd16, 1'b1, 1'b1);
    set_s1(128'hB1, 5'd8, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if ({s0_din_ready, s1_din_ready} !== 2'b10) begin errors++; $display("FAIL fp_ready[%0d]: got %b expected 10", i, {s0_din_ready, s1_din_ready}); end
      @(posedge clk); #1;
      checks++; if (m_dout_src !== 1'b0 || m_dout !== 128'hA0) begin errors++; $display("FAIL fp_src[%0d]: got src %b data %0h expected src 0 data a0", i, m_dout_src, m_dout); end
      exp_cnt0++;
    end
    s0_din_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (m_dout_src !== 1'b1 || m_dout !== 128'hB1) begin errors++; $display("FAIL fp_s1: got src %b data %0h expected src 1 data b1", m_dout_src, m_dout); end
    exp_cnt1++;
    s1_din_valid = 1'b0;
    checks++; if (pkt_cnt0 !== exp_cnt0 || pkt_cnt1 !== exp_cnt1) begin errors++; $display("FAIL fp_cnt: got %0d/%0d expected %0d/%0d", pkt_cnt0, pkt_cnt1, exp_cnt0, exp_cnt1); end
    @(posedge clk); #1;
  endtask
`endif

  task automatic test_lock();
    logic [DW-1:0] dat [3];
    logic [SW-1:0] sz  [3];
    dat[0] = 128'hD0; dat[1] = 128'hD1; dat[2] = 128'hD2;
    sz[0]  = 5'd16;   sz[1]  = 5'd16;   sz[2]  = 5'd5;
    set_s1(128'hC1, 5'd16, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      set_s0(dat[i], sz[i], (i == 2), 1'b1);
      @(negedge clk);
      checks++; if ({s0_din_ready, s1_din_ready} !== 2'b10) begin errors++; $display("FAIL lock_ready[%0d]: got %b expected 10", i, {s0_din_ready, s1_din_ready}); end
      @(posedge clk); #1;
      checks++; if (m_dout !== dat[i] || m_dout_size !== sz[i] || m_dout_last !== (i == 2)) begin errors++; $display("FAIL lock_beat[%0d]: got %0h size %0d last %b", i, m_dout, m_dout_size, m_dout_last); end
      checks++; if (owner !== ((i < 2) ? 2'b01 : 2'b00)) begin errors++; $display("FAIL lock_owner[%0d]: got %b", i, owner); end
      if (i == 1) begin
        s0_din_valid = 1'b0;
        repeat (2) begin
          @(negedge clk);
          checks++; if (s1_din_ready !== 1'b0 || owner !== 2'b01) begin errors++; $display("FAIL lock_hold: got s1_ready %b owner %b expected 0/01", s1_din_ready, owner); end
          @(posedge clk); #1;
        end
      end
    end
    s0_din_valid = 1'b0;
    exp_cnt0++;
    checks++; if (pkt_cnt0 !== exp_cnt0) begin errors++; $display("FAIL lock_cnt0: got %0d expected %0d", pkt_cnt0, exp_cnt0); end
    @(negedge clk);
    checks++; if ({s0_din_ready, s1_din_ready} !== 2'b01) begin errors++; $display("FAIL lock_s1_ready: got %b expected 01", {s0_din_ready, s1_din_ready}); end
    @(posedge clk); #1;
    checks++; if (m_dout_src !== 1'b1 || m_dout !== 128'hC1) begin errors++; $display("FAIL lock_s1_beat: got src %b data %0h expected 1/c1", m_dout_src, m_dout); end
    s1_din_valid = 1'b0;
    exp_cnt1++;
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    m_dout_ready = 1'b0;
    set_s0(128'hE0, 5'd7, 1'b1, 1'b1);
    @(posedge clk); #1;
    checks++; if (m_dout !== 128'hE0 || m_dout_valid !== 1'b1) begin errors++; $display("FAIL bp_load: got %0h valid %b expected e0/1", m_dout, m_dout_valid); end
    exp_cnt0++;
    s0_din_valid = 1'b0;
    set_s1(128'hF1, 5'd9, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if ({s0_din_ready, s1_din_ready} !== 2'b00) begin errors++; $display("FAIL bp_ready[%0d]: got %b expected 00", i, {s0_din_ready, s1_din_ready}); end
      checks++; if (m_dout !== 128'hE0 || m_dout_valid !== 1'b1) begin errors++; $display("FAIL bp_hold[%0d]: got %0h valid %b expected e0/1", i, m_dout, m_dout_valid); end
    end
    m_dout_ready = 1'b1;
    #1;
    checks++; if ({s0_din_ready, s1_din_ready} !== 2'b01) begin errors++; $display("FAIL bp_release_ready: got %b expected 01", {s0_din_ready, s1_din_ready}); end
    @(posedge clk); #1;
    checks++; if (m_dout !== 128'hF1 || m_dout_src !== 1'b1 || m_dout_valid !== 1'b1 || m_dout_size !== 5'd9) begin errors++; $display("FAIL bp_swap: got %0h src %b valid %b size %0d expected f1/1/1/9", m_dout, m_dout_src, m_dout_valid, m_dout_size); end
    s1_din_valid = 1'b0;
    exp_cnt1++;
    checks++; if (pkt_cnt0 !== exp_cnt0 || pkt_cnt1 !== exp_cnt1) begin errors++; $display("FAIL bp_cnt: got %0d/%0d expected %0d/%0d", pkt_cnt0, pkt_cnt1, exp_cnt0, exp_cnt1); end
    @(posedge clk); #1;
    checks++; if (m_dout_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got valid %b expected 0", m_dout_valid); end
  endtask

  task automatic test_reset_mid_packet();
    set_s1(128'h60, 5'd16, 1'b0, 1'b1);
    @(negedge clk);
    checks++; if (s1_din_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_grant: got %b expected 1", s1_din_ready); end
    @(posedge clk); #1;
    checks++; if (owner !== 2'b10) begin errors++; $display("FAIL rst_mid_lock: got %b expected 10", owner); end
    set_s1(128'h61, 5'd16, 1'b0, 1'b1);
    #2 rstn = 1'b0;
    #1;
    checks++; if (owner !== 2'b00 || m_dout_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_pulse: got owner %b valid %b expected 00/0", owner, m_dout_valid); end
    checks++; if ({s0_din_ready, s1_din_ready} !== 2'b00 || m_dout !== '0) begin errors++; $display("FAIL rst_mid_outs: got ready %b data %0h expected 00/0", {s0_din_ready, s1_din_ready}, m_dout); end
    checks++; if (pkt_cnt0 !== 8'd0 || pkt_cnt1 !== 8'd0) begin errors++; $display("FAIL rst_mid_cnt: got %0d/%0d expected 0/0", pkt_cnt0, pkt_cnt1); end
    exp_cnt0 = 8'd0; exp_cnt1 = 8'd0;
    set_s0(128'h70, 5'd3, 1'b1, 1'b1);
    set_s1(128'h71, 5'd4, 1'b1, 1'b1);
    @(posedge clk); #1;
    checks++; if (owner !== 2'b00 || m_dout_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_held: got owner %b valid %b expected 00/0", owner, m_dout_valid); end
    @(negedge clk) rstn = 1'b1;
    #1;
    checks++; if (m_dout_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_noemit: got valid %b expected 0", m_dout_valid); end
    checks++; if ({s0_din_ready, s1_din_ready} !== 2'b10) begin errors++; $display("FAIL rst_mid_tie: got %b expected 10", {s0_din_ready, s1_din_ready}); end
    @(posedge clk); #1;
    checks++; if (m_dout_src !== 1'b0 || m_dout !== 128'h70) begin errors++; $display("FAIL rst_mid_first: got src %b data %0h expected 0/70", m_dout_src, m_dout); end
    exp_cnt0++;
    set_s0('0, '0, 1'b0, 1'b0);
    set_s1('0, '0, 1'b0, 1'b0);
    @(posedge clk); #1;
  endtask

  task automatic test_cnt_wrap();
    @(negedge clk) rstn = 1'b0;
    @(negedge clk) rstn = 1'b1;
    exp_cnt0 = 8'd0; exp_cnt1 = 8'd0;
    set_s0(128'h90, 5'd1, 1'b1, 1'b1);
    @(posedge clk); #1;
    repeat (254) @(posedge clk);
    #1;
    checks++; if (pkt_cnt0 !== 8'd255) begin errors++; $display("FAIL wrap_255: got %0d expected 255", pkt_cnt0); end
    @(posedge clk); #1;
    checks++; if (pkt_cnt0 !== 8'd0 || pkt_cnt1 !== 8'd0) begin errors++; $display("FAIL wrap_0: got %0d/%0d expected 0/0", pkt_cnt0, pkt_cnt1); end
    s0_din_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
`ifdef GIMLI_OUT_ARB_FIXED_PRIORITY_EN
    test_fixed_priority();
`else
    test_round_robin();
`endif
    test_lock();
    test_backpressure();
    test_reset_mid_packet();
    test_cnt_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
